sram_access_scheduler: RTL

SRAM_ACCESS_SCHEDULER -- requirements
Module: sram_access_scheduler

---
 rtl/sram_access_scheduler.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_access_scheduler.sv
// Milestone sequencer: arbitrates one SRAM port between UART load, M2, M1 and VGA.
// Start levels, receiver pulses and status flags are registered; the SRAM mux follows the state.
module sram_access_scheduler #(
  parameter logic [25:0] UART_TIMEOUT    = 26'd49999999,
  parameter logic [25:0] WATCHDOG_CYCLES = 26'd50000000,
  parameter logic        SIM_AUTOSTART   = 1'b0,
  parameter logic [25:0] AUTOSTART_DELAY = 26'd10
) (
  input  logic        CLOCK_50_I,
  input  logic        Reset,
  input  logic        Load_request,
  input  logic [17:0] UART_SRAM_address,
  input  logic [15:0] UART_SRAM_write_data,
  input  logic        UART_SRAM_we_n,
  output logic        UART_rx_initialize,
  output logic        UART_rx_enable,
  output logic        M2_start,
  input  logic        M2_finish,
  input  logic [17:0] M2_SRAM_address,
  input  logic [15:0] M2_SRAM_write_data,
  input  logic        M2_SRAM_we_n,
  output logic        M1_start,
  input  logic        M1_finish,
  input  logic [17:0] M1_SRAM_address,
  input  logic [15:0] M1_SRAM_write_data,
  input  logic        M1_SRAM_we_n,
  input  logic [17:0] VGA_SRAM_address,
  output logic        VGA_enable,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic [2:0]  State,
  output logic        Error_flag
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_UART_INIT = 3'd1;
  localparam logic [2:0] S_UART_RX   = 3'd2;
  localparam logic [2:0] S_M2_RUN    = 3'd3;
  localparam logic [2:0] S_M1_RUN    = 3'd4;
  localparam logic [2:0] S_ERROR     = 3'd5;

  logic [2:0]  state_q, state_d;
  logic        m1_start_q, m1_start_d;
  logic        m2_start_q, m2_start_d;
  logic        rx_init_q, rx_init_d;
  logic        rx_en_q, rx_en_d;
  logic        vga_en_q, vga_en_d;
  logic        err_q, err_d;
  logic        auto_done_q, auto_done_d;
  logic [25:0] timer_q, timer_d;
  logic [25:0] wd_q, wd_d;
  logic [25:0] auto_cnt_q, auto_cnt_d;
  logic [25:0] wd_inc;
  logic        wd_expire;
  logic        run_q, run_d;

  assign wd_inc    = wd_q + 26'd1;
  assign wd_expire = (wd_inc == WATCHDOG_CYCLES);
  assign run_q     = (state_q == S_M2_RUN) || (state_q == S_M1_RUN);
  assign run_d     = (state_d == S_M2_RUN) || (state_d == S_M1_RUN);

  always_comb begin
    state_d     = state_q;
    m1_start_d  = m1_start_q;
    m2_start_d  = m2_start_q;
    rx_init_d   = 1'b0;
    rx_en_d     = 1'b0;
    vga_en_d    = vga_en_q;
    err_d       = err_q;
    auto_done_d = auto_done_q;
    // auto_cnt_d is the cycle count since release including this edge
    auto_cnt_d  = (&auto_cnt_q) ? auto_cnt_q : auto_cnt_q + 26'd1;
    if (rx_init_q || !UART_SRAM_we_n) timer_d = '0;
    else if (&timer_q)                timer_d = timer_q;
    else                              timer_d = timer_q + 26'd1;

    case (state_q)
      S_IDLE: begin
        if (Load_request) begin
          rx_init_d = 1'b1;
          vga_en_d  = 1'b0;
          state_d   = S_UART_INIT;
        end else if (SIM_AUTOSTART && !auto_done_q &&
                     auto_cnt_d == AUTOSTART_DELAY) begin
          auto_done_d = 1'b1;
          m2_start_d  = 1'b1;
          state_d     = S_M2_RUN;
        end
      end
      S_UART_INIT: begin
        rx_en_d = 1'b1;
        state_d = S_UART_RX;
      end
      S_UART_RX: begin
        if (timer_q == UART_TIMEOUT && UART_SRAM_address != '0) begin
          rx_init_d  = 1'b1;
          m2_start_d = 1'b1;
          state_d    = S_M2_RUN;
        end
      end
      S_M2_RUN: begin
        if (M2_finish) begin
          m2_start_d = 1'b0;
          m1_start_d = 1'b1;
          state_d    = S_M1_RUN;
        end else if (wd_expire) begin
          m2_start_d = 1'b0;
          m1_start_d = 1'b0;
          err_d      = 1'b1;
          vga_en_d   = 1'b1;
          state_d    = S_ERROR;
        end
      end
      S_M1_RUN: begin
        if (M1_finish) begin
          m1_start_d = 1'b0;
          vga_en_d   = 1'b1;
          state_d    = S_IDLE;
        end else if (wd_expire) begin
          m2_start_d = 1'b0;
          m1_start_d = 1'b0;
          err_d      = 1'b1;
          vga_en_d   = 1'b1;
          state_d    = S_ERROR;
        end
      end
      S_ERROR: begin
        if (Load_request) begin
          err_d     = 1'b0;
          rx_init_d = 1'b1;
          vga_en_d  = 1'b0;
          state_d   = S_UART_INIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (run_d && state_d != state_q) wd_d = '0;
    else if (run_q)                  wd_d = wd_inc;
    else                             wd_d = wd_q;
  end

  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      m1_start_q  <= 1'b0;
      m2_start_q  <= 1'b0;
      rx_init_q   <= 1'b0;
      rx_en_q     <= 1'b0;
      vga_en_q    <= 1'b1;
      err_q       <= 1'b0;
      auto_done_q <= 1'b0;
      timer_q     <= '0;
      wd_q        <= '0;
      auto_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      m1_start_q  <= m1_start_d;
      m2_start_q  <= m2_start_d;
      rx_init_q   <= rx_init_d;
      rx_en_q     <= rx_en_d;
      vga_en_q    <= vga_en_d;
      err_q       <= err_d;
      auto_done_q <= auto_done_d;
      timer_q     <= timer_d;
      wd_q        <= wd_d;
      auto_cnt_q  <= auto_cnt_d;
    end
  end

  // Ownership follows the registered state so a reset hands SRAM to VGA at once
  always_comb begin
    SRAM_address    = VGA_SRAM_address;
    SRAM_write_data = 16'd0;
    SRAM_we_n       = 1'b1;
    case (state_q)
      S_UART_INIT, S_UART_RX: begin
        SRAM_address    = UART_SRAM_address;
        SRAM_write_data = UART_SRAM_write_data;
        SRAM_we_n       = UART_SRAM_we_n;
      end
      S_M2_RUN: begin
        SRAM_address    = M2_SRAM_address;
        SRAM_write_data = M2_SRAM_write_data;
        SRAM_we_n       = M2_SRAM_we_n;
      end
      S_M1_RUN: begin
        SRAM_address    = M1_SRAM_address;
        SRAM_write_data = M1_SRAM_write_data;
        SRAM_we_n       = M1_SRAM_we_n;
      end
      default: ;
    endcase
  end

  assign State              = state_q;
  assign M1_start           = m1_start_q;
  assign M2_start           = m2_start_q;
  assign UART_rx_initialize = rx_init_q;
  assign UART_rx_enable     = rx_en_q;
  assign VGA_enable         = vga_en_q;
  assign Error_flag         = err_q;

endmodule
